// File: rtl/stream_demux.sv
// One-input, NCH-output stream demultiplexer with per-channel output
// registers, broadcast delivery and a saturating count of misrouted words.
module stream_demux #(
  parameter int WIDTH = 32,
  parameter int NCH = 4,
  parameter int CNTW = 8,
  localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 drop_err,
  output logic [CNTW-1:0]      drop_cnt
);

  logic [NCH-1:0]   vld;
  logic [NCH-1:0]   can;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   pop;
  logic [WIDTH-1:0] dat [NCH];
  logic             sel_ok;
  logic             in_fire;
  logic             drop;

  assign sel_ok  = 32'(in_sel) < NCH;
  assign can     = ~vld | out_ready;
  assign in_fire = in_valid & in_ready;
  assign drop    = in_fire & ~in_bcast & ~sel_ok;

  // Out-of-range selects are always accepted so they can be dropped.
  always_comb begin
    in_ready = 1'b1;
    unique case (1'b1)
      in_bcast:           in_ready = &can;
      !in_bcast && sel_ok: in_ready = can[in_sel];
      default:            in_ready = 1'b1;
    endcase
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign load[k] = in_fire &
      (in_bcast | (sel_ok & (in_sel == SELW'(k))));
    assign pop[k] = vld[k] & out_ready[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld[k] <= 1'b0;
        dat[k] <= '0;
      end else if (load[k]) begin
        vld[k] <= 1'b1;
        dat[k] <= in_data;
      end else if (pop[k]) begin
        vld[k] <= 1'b0;
        dat[k] <= '0;
      end
    end

    assign out_data[k*WIDTH +: WIDTH] = dat[k];
  end

  assign out_valid = vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop_err <= drop;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNTW'(1);
    end
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 32, width of the data word in bits.
REQ-002 Parameter NCH, default 4, number of output channels; legal range 2..16.
REQ-003 Parameter CNTW, default 8, width of the drop counter.
REQ-004 Derived SELW = max(1, clog2(NCH)), width of the select field.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 in_data  input  WIDTH  upstream word.
REQ-010 in_sel  input  SELW  destination channel index.
REQ-011 in_bcast  input  1  deliver the word to all channels; in_sel is ignored.
REQ-012 out_valid  output  NCH  bit k: channel k holds a word.
REQ-013 out_ready  input  NCH  bit k: channel k consumer takes its word.
REQ-014 out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-015 drop_err  output  1  one-cycle pulse when a word is dropped.
REQ-016 drop_cnt  output  CNTW  saturating count of dropped words.

Function
REQ-017 Define the input transfer as in_fire = in_valid & in_ready, and per-channel can_k = ~out_valid[k] | out_ready[k].
REQ-018 in_ready SHALL be combinational: with in_bcast=1, the AND of all can_k; with in_bcast=0 and in_sel<NCH, can_in_sel; with in_bcast=0 and in_sel>=NCH, 1.
REQ-019 A unicast in_fire with in_sel<NCH SHALL set out_valid[in_sel]=1 and load in_data into channel in_sel on the same edge (latency 1 cycle).
REQ-020 A broadcast in_fire SHALL load in_data into every channel and set every out_valid bit on the same edge.
REQ-021 A channel output handshake occurs when out_valid[k] & out_ready[k]; without a simultaneous load, out_valid[k] SHALL clear and channel k data SHALL become 0 on that edge.
REQ-022 A simultaneous handshake and load on the same channel SHALL keep out_valid[k]=1 and present the new word; no word is lost or duplicated.
REQ-023 While out_valid[k]=0, channel k data SHALL read as all zeros.
REQ-024 While out_valid[k]=1 and out_ready[k]=0, channel k data SHALL hold stable.
REQ-025 Channels SHALL be independent: a stall on channel j SHALL NOT block unicast traffic to channel k != j.
REQ-026 A unicast in_fire with in_sel>=NCH (possible only when NCH is not a power of 2) SHALL drop the word, pulse drop_err high for exactly the following cycle, and increment drop_cnt.
REQ-027 drop_cnt SHALL saturate at 2^CNTW-1 and never wrap.
REQ-028 in_data, in_sel and in_bcast SHALL be ignored when in_valid=0.
REQ-029 Throughput SHALL be one word per cycle when the destination channels are ready.

Reset
REQ-030 While rst_n=0: out_valid=0, out_data=0, drop_err=0, drop_cnt=0, asynchronously and independent of clk.
REQ-031 in_ready during reset SHALL follow REQ-018 using the reset register values; no in_fire during reset SHALL change any state.
REQ-032 Reset asserted mid-transfer SHALL discard all held words; the first edge after release SHALL behave as from an empty state.

Verification
REQ-033 Unicast: send 32'hAAAA5555 with sel=0, then 32'h12345678 with sel=1, with all out_ready=1 -> each appears on its channel one cycle after its fire, and all other channels read 0.
REQ-034 Backpressure: out_ready[2]=0, send 32'h87654321 to ch2, then a second word to ch2 -> in_ready=0 for the second word and ch2 holds 32'h87654321; raise out_ready[2] -> the second word loads on the same edge as the pop.
REQ-035 Independence: ch1 stalled and full, send a word to ch3 -> accepted and delivered in 1 cycle.
REQ-036 Broadcast: NCH=4, ch0 full and stalled, bcast 32'hDEADBEEF -> in_ready=0; release ch0 -> all four channels present 32'hDEADBEEF the next cycle.
REQ-037 Drop: NCH=3, CNTW=2, five fires with sel=3 -> five drop_err pulses, drop_cnt sequence 1,2,3,3,3, and no out_valid bit set.
REQ-038 Reset: with channels full, pulse rst_n low between edges -> out_valid=0 and out_data=0 immediately, drop_cnt=0.
